// File: rtl/alu_arb_pkg.sv
// Shared types and opcode helpers for the ALU operation arbiter.
package alu_arb_pkg;

   localparam int unsigned ALU_OPW = 4;
   localparam int unsigned CNT_W   = 4;

   typedef enum logic [ALU_OPW-1:0] {
      ADD = 4'd0,
      SUB = 4'd1,
      MUL = 4'd2,
      DIV = 4'd3,
      MOD = 4'd4,
      SHL = 4'd5,
      SHR = 4'd6,
      AND = 4'd7,
      OR  = 4'd8,
      XOR = 4'd9,
      MOV = 4'd10
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   // Encodings 11..15 have no ALU function behind them.
   function automatic logic is_illegal(input logic [ALU_OPW-1:0] op);
      return op > ALU_OPW'(MOV);
   endfunction

   // Divide and modulo need a non-zero divisor magnitude.
   function automatic logic is_divmod(input logic [ALU_OPW-1:0] op);
      return (op == ALU_OPW'(DIV)) || (op == ALU_OPW'(MOD));
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a tie goes to the requester named by i_prio.
module rr_arb2 (
   input  logic [1:0] i_valid,
   input  logic       i_prio,
   output logic       o_grant,
   output logic       o_any
);

   // Pick the lone valid requester, or the priority holder on a tie.
   always_comb begin
      o_any = |i_valid;
      case (i_valid)
         2'b11:   o_grant = i_prio;
         2'b10:   o_grant = 1'b1;
         default: o_grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_op_arbiter.sv
// Shares one combinational ALU between the decrypt pipeline (0) and the host port (1).
// Captures the granted operands, waits a fixed latency, returns one tagged response.
module alu_op_arbiter
   import alu_arb_pkg::*;
#(
   parameter int unsigned N   = 6,
   parameter int unsigned OPW = 4,
   parameter int unsigned LAT = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [1:0]       i_req_valid,
   output logic [1:0]       o_req_ready,
   input  logic [2*OPW-1:0] i_req_op,
   input  logic [2*N-1:0]   i_req_a,
   input  logic [2*N-1:0]   i_req_b,
   output logic [N-1:0]     o_alu_a,
   output logic [N-1:0]     o_alu_b,
   output logic [OPW-1:0]   o_alu_op,
   input  logic [2*N-1:0]   i_alu_result,
   output logic [1:0]       o_rsp_valid,
   input  logic [1:0]       i_rsp_ready,
   output logic [2*N-1:0]   o_rsp_data,
   output logic             o_rsp_err
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

   arb_state_e       r_state;
   arb_state_e       w_state_next;
   logic             r_prio;
   logic             r_owner;
   logic [CNT_W-1:0] r_cnt;
   logic [N-1:0]     r_alu_a;
   logic [N-1:0]     r_alu_b;
   logic [OPW-1:0]   r_alu_op;
   logic [2*N-1:0]   r_rsp_data;
   logic             r_rsp_err;

   logic             w_grant;
   logic             w_any;
   logic [OPW-1:0]   w_sel_op;
   logic [N-1:0]     w_sel_a;
   logic [N-1:0]     w_sel_b;
   logic             w_sel_bad;
   logic             w_req_hs;
   logic             w_wait_done;

   rr_arb2 u_rr_arb2 (
      .i_valid (i_req_valid),
      .i_prio  (r_prio),
      .o_grant (w_grant),
      .o_any   (w_any)
   );

   // Steer the granted requester's fields and screen them before issue.
   always_comb begin
      w_sel_op    = w_grant ? i_req_op[2*OPW-1:OPW] : i_req_op[OPW-1:0];
      w_sel_a     = w_grant ? i_req_a[2*N-1:N]      : i_req_a[N-1:0];
      w_sel_b     = w_grant ? i_req_b[2*N-1:N]      : i_req_b[N-1:0];
      // Sign bit ignored: both +0 and -0 count as a zero divisor.
      w_sel_bad   = is_illegal(w_sel_op) ||
                    (is_divmod(w_sel_op) && (w_sel_b[N-2:0] == '0));
      w_req_hs    = (r_state == IDLE) && w_any;
      w_wait_done = (r_state == WAIT) && (r_cnt == '0);
   end

   // Next-state decode plus the handshake outputs of each state.
   always_comb begin
      w_state_next = r_state;
      o_req_ready  = 2'b00;
      o_rsp_valid  = 2'b00;
      case (r_state)
         IDLE: begin
            // Ready is held low while reset is asserted so nothing looks accepted.
            if (w_any && i_rst_n) begin
               o_req_ready  = w_grant ? 2'b10 : 2'b01;
               w_state_next = w_sel_bad ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == '0) begin
               w_state_next = RESP;
            end
         end
         RESP: begin
            o_rsp_valid = r_owner ? 2'b10 : 2'b01;
            if (i_rsp_ready[r_owner]) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Operand capture, latency countdown and response capture.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_prio     <= 1'b0;
         r_owner    <= 1'b0;
         r_cnt      <= '0;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_op   <= OPW'(ADD);
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         if (w_req_hs) begin
            r_prio  <= ~w_grant;
            r_owner <= w_grant;
            if (w_sel_bad) begin
               // Screened requests never reach the ALU; its inputs stay put.
               r_rsp_data <= '0;
               r_rsp_err  <= 1'b1;
            end else begin
               r_alu_a  <= w_sel_a;
               r_alu_b  <= w_sel_b;
               r_alu_op <= w_sel_op;
               r_cnt    <= CNT_INIT;
            end
         end
         if (w_wait_done) begin
            r_rsp_data <= i_alu_result;
            r_rsp_err  <= 1'b0;
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign o_alu_a    = r_alu_a;
   assign o_alu_b    = r_alu_b;
   assign o_alu_op   = r_alu_op;
   assign o_rsp_data = r_rsp_data;
   assign o_rsp_err  = r_rsp_err;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Bench for alu_op_arbiter: two instances (latency 1 and 3) driven from request queues,
// checked every cycle against a transaction-level model of grant, latency and result.
module tb_alu_op_arbiter;

   typedef struct packed {
      logic [3:0] op;
      logic [5:0] a;
      logic [5:0] b;
   } req_t;

   typedef struct packed {
      logic        owner;
      logic        err;
      logic [11:0] data;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid  [2] = '{2'b00, 2'b00};
   logic [1:0]  req_ready  [2];
   logic [7:0]  req_op     [2] = '{8'h00, 8'h00};
   logic [11:0] req_a      [2] = '{12'h000, 12'h000};
   logic [11:0] req_b      [2] = '{12'h000, 12'h000};
   logic [5:0]  alu_a      [2];
   logic [5:0]  alu_b      [2];
   logic [3:0]  alu_op     [2];
   logic [11:0] alu_result [2];
   logic [1:0]  rsp_valid  [2];
   logic [1:0]  rsp_ready  [2] = '{2'b11, 2'b11};
   logic [11:0] rsp_data   [2];
   logic        rsp_err    [2];

   int   n_checks = 0;
   int   n_errors = 0;

   req_t pend_q  [2][2][$];
   rsp_t rsp_log [2][$];
   int   grant_log[$];
   bit   rand_en  [2] = '{1'b0, 1'b0};
   int   rsp_mode [2] = '{1, 1};
   logic [1:0] hs [2] = '{2'b00, 2'b00};

   // Reference model state, one slot per instance.
   bit          m_busy  [2];
   logic        m_owner [2];
   logic        m_prio  [2];
   int          m_due   [2];
   int          m_cyc   [2];
   logic [11:0] m_data  [2];
   logic        m_err   [2];
   logic [5:0]  m_a     [2];
   logic [5:0]  m_b     [2];
   logic [3:0]  m_op    [2];
   int          n_rsp   [2];

   always #5 clk = ~clk;

   // Stand-in for the Operations ALU + result mux.
   function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [5:0] a,
                                          input logic [5:0] b);
      logic [11:0] xa;
      logic [11:0] xb;
      xa = {6'd0, a};
      xb = {6'd0, b};
      case (op)
         4'd0:    return xa + xb;
         4'd1:    return xa - xb;
         4'd2:    return xa * xb;
         4'd3:    return (xb != 0) ? xa / xb : 12'd0;
         4'd4:    return (xb != 0) ? xa % xb : 12'd0;
         4'd5:    return xa << b[2:0];
         4'd6:    return xa >> b[2:0];
         4'd7:    return xa & xb;
         4'd8:    return xa | xb;
         4'd9:    return xa ^ xb;
         4'd10:   return xa;
         default: return 12'hfff;
      endcase
   endfunction

   function automatic logic exp_err(input logic [3:0] op, input logic [5:0] b);
      return (op >= 4'd11) || (((op == 4'd3) || (op == 4'd4)) && (b[4:0] == 5'd0));
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic req_t rand_req();
      req_t t;
      t.op = 4'($urandom_range(15));
      t.a  = 6'($urandom);
      t.b  = ($urandom_range(3) == 0) ? {1'($urandom), 5'd0} : 6'($urandom);
      return t;
   endfunction

   alu_op_arbiter #(.N(6), .OPW(4), .LAT(1)) u_dut_l1 (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid[0]),
      .o_req_ready  (req_ready[0]),
      .i_req_op     (req_op[0]),
      .i_req_a      (req_a[0]),
      .i_req_b      (req_b[0]),
      .o_alu_a      (alu_a[0]),
      .o_alu_b      (alu_b[0]),
      .o_alu_op     (alu_op[0]),
      .i_alu_result (alu_result[0]),
      .o_rsp_valid  (rsp_valid[0]),
      .i_rsp_ready  (rsp_ready[0]),
      .o_rsp_data   (rsp_data[0]),
      .o_rsp_err    (rsp_err[0])
   );

   alu_op_arbiter #(.N(6), .OPW(4), .LAT(3)) u_dut_l3 (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid[1]),
      .o_req_ready  (req_ready[1]),
      .i_req_op     (req_op[1]),
      .i_req_a      (req_a[1]),
      .i_req_b      (req_b[1]),
      .o_alu_a      (alu_a[1]),
      .o_alu_b      (alu_b[1]),
      .o_alu_op     (alu_op[1]),
      .i_alu_result (alu_result[1]),
      .o_rsp_valid  (rsp_valid[1]),
      .i_rsp_ready  (rsp_ready[1]),
      .o_rsp_data   (rsp_data[1]),
      .o_rsp_err    (rsp_err[1])
   );

   assign alu_result[0] = alu_fn(alu_op[0], alu_a[0], alu_b[0]);
   assign alu_result[1] = alu_fn(alu_op[1], alu_a[1], alu_b[1]);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_idle(input int d, input int budget);
      int k;
      k = 0;
      while ((pend_q[d][0].size() != 0 || pend_q[d][1].size() != 0 || m_busy[d]) &&
             k < budget) begin
         step(1);
         k++;
      end
      check_eq($sformatf("d%0d_drain_in_budget", d), 32'(k < budget), 32'd1);
   endtask

   // Requesters: present the queue head, retire it once accepted.
   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 2; r++) begin
            if (hs[d][r]) begin
               void'(pend_q[d][r].pop_front());
            end
            if (rand_en[d] && pend_q[d][r].size() == 0 && $urandom_range(2) == 0) begin
               pend_q[d][r].push_back(rand_req());
            end
            if (pend_q[d][r].size() != 0) begin
               req_valid[d][r]       = 1'b1;
               req_op[d][r*4 +: 4]   = pend_q[d][r][0].op;
               req_a[d][r*6 +: 6]    = pend_q[d][r][0].a;
               req_b[d][r*6 +: 6]    = pend_q[d][r][0].b;
            end else begin
               req_valid[d][r] = 1'b0;
            end
         end
         case (rsp_mode[d])
            0:       rsp_ready[d] = 2'($urandom);
            1:       rsp_ready[d] = 2'b11;
            default: rsp_ready[d] = 2'b00;
         endcase
      end
   end

   // Per-cycle comparison against the model, then advance the model over the next edge.
   always @(negedge clk) begin
      logic [1:0]  v;
      logic        g;
      logic [3:0]  op;
      logic [5:0]  a;
      logic [5:0]  b;
      for (int d = 0; d < 2; d++) begin
         hs[d] = req_valid[d] & req_ready[d];
         if (!rst_n) begin
            check_eq($sformatf("d%0d_ready_in_reset", d), 32'(req_ready[d]), 32'd0);
            m_busy[d] = 1'b0;
            m_prio[d] = 1'b0;
            m_a[d]    = 6'd0;
            m_b[d]    = 6'd0;
            m_op[d]   = 4'd0;
         end else begin
            check_eq($sformatf("d%0d_alu_a", d), 32'(alu_a[d]), 32'(m_a[d]));
            check_eq($sformatf("d%0d_alu_b", d), 32'(alu_b[d]), 32'(m_b[d]));
            check_eq($sformatf("d%0d_alu_op", d), 32'(alu_op[d]), 32'(m_op[d]));
            if (!m_busy[d]) begin
               v = req_valid[d];
               g = (v == 2'b11) ? m_prio[d] : v[1];
               check_eq($sformatf("d%0d_req_ready", d), 32'(req_ready[d]),
                        (v == 2'b00) ? 32'd0 : (g ? 32'd2 : 32'd1));
               check_eq($sformatf("d%0d_rsp_valid_idle", d), 32'(rsp_valid[d]), 32'd0);
               if (v != 2'b00) begin
                  op          = req_op[d][int'(g)*4 +: 4];
                  a           = req_a[d][int'(g)*6 +: 6];
                  b           = req_b[d][int'(g)*6 +: 6];
                  m_busy[d]   = 1'b1;
                  m_owner[d]  = g;
                  m_prio[d]   = ~g;
                  m_err[d]    = exp_err(op, b);
                  m_data[d]   = m_err[d] ? 12'd0 : alu_fn(op, a, b);
                  m_due[d]    = m_cyc[d] + 1 + (m_err[d] ? 0 : lat_of(d));
                  if (!m_err[d]) begin
                     m_a[d]  = a;
                     m_b[d]  = b;
                     m_op[d] = op;
                  end
                  if (d == 0) begin
                     grant_log.push_back(int'(g));
                  end
               end
            end else begin
               check_eq($sformatf("d%0d_ready_busy", d), 32'(req_ready[d]), 32'd0);
               if (m_cyc[d] < m_due[d]) begin
                  check_eq($sformatf("d%0d_rsp_valid_early", d), 32'(rsp_valid[d]), 32'd0);
               end else begin
                  check_eq($sformatf("d%0d_rsp_valid", d), 32'(rsp_valid[d]),
                           m_owner[d] ? 32'd2 : 32'd1);
                  check_eq($sformatf("d%0d_rsp_data", d), 32'(rsp_data[d]), 32'(m_data[d]));
                  check_eq($sformatf("d%0d_rsp_err", d), 32'(rsp_err[d]), 32'(m_err[d]));
                  if (rsp_ready[d][m_owner[d]]) begin
                     m_busy[d] = 1'b0;
                     n_rsp[d]++;
                     rsp_log[d].push_back('{owner: m_owner[d], err: m_err[d],
                                            data: m_data[d]});
                  end
               end
            end
         end
         m_cyc[d]++;
      end
   end

   initial begin
      int   k;
      int   base0;
      int   base1;
      rsp_t e;
      for (int d = 0; d < 2; d++) begin
         m_busy[d] = 1'b0;
         m_cyc[d]  = 0;
         n_rsp[d]  = 0;
      end

      // Reset values of the registered outputs.
      rst_n = 1'b0;
      step(3);
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("d%0d_rst_alu_a", d), 32'(alu_a[d]), 32'd0);
         check_eq($sformatf("d%0d_rst_alu_b", d), 32'(alu_b[d]), 32'd0);
         check_eq($sformatf("d%0d_rst_alu_op", d), 32'(alu_op[d]), 32'd0);
         check_eq($sformatf("d%0d_rst_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
         check_eq($sformatf("d%0d_rst_rsp_data", d), 32'(rsp_data[d]), 32'd0);
         check_eq($sformatf("d%0d_rst_rsp_err", d), 32'(rsp_err[d]), 32'd0);
      end
      rst_n = 1'b1;
      step(1);

      // Single ADD 3+5 from requester 0.
      pend_q[0][0].push_back('{op: 4'd0, a: 6'd3, b: 6'd5});
      wait_idle(0, 50);
      e = rsp_log[0].pop_back();
      check_eq("t1_data", 32'(e.data), 32'd8);
      check_eq("t1_err", 32'(e.err), 32'd0);
      check_eq("t1_owner", 32'(e.owner), 32'd0);

      // Both requesters valid from reset: strict alternation.
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int r = 0; r < 2; r++) begin
            pend_q[0][r].push_back('{op: 4'd9, a: 6'(8 * r + i), b: 6'd1});
         end
      end
      step(2);
      grant_log.delete();
      rsp_log[0].delete();
      rst_n = 1'b1;
      wait_idle(0, 200);
      check_eq("t2_grant_count", 32'(grant_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
         check_eq($sformatf("t2_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));
      end
      for (int i = 0; i < 8 && i < rsp_log[0].size(); i++) begin
         check_eq($sformatf("t2_data_%0d", i), 32'(rsp_log[0][i].data),
                  32'((8 * (i % 2) + i / 2) ^ 1));
      end

      // DIV by -0 from requester 1: error, ALU inputs untouched.
      rsp_log[0].delete();
      pend_q[0][1].push_back('{op: 4'd3, a: 6'd9, b: 6'b100000});
      wait_idle(0, 50);
      e = rsp_log[0].pop_back();
      check_eq("t3_err", 32'(e.err), 32'd1);
      check_eq("t3_data", 32'(e.data), 32'd0);
      check_eq("t3_owner", 32'(e.owner), 32'd1);
      check_eq("t3_alu_a_kept", 32'(alu_a[0]), 32'd11);
      check_eq("t3_alu_b_kept", 32'(alu_b[0]), 32'd1);
      check_eq("t3_alu_op_kept", 32'(alu_op[0]), 32'd9);

      // Illegal opcode followed by MUL 3*4.
      rsp_log[0].delete();
      pend_q[0][0].push_back('{op: 4'd13, a: 6'd1, b: 6'd2});
      pend_q[0][0].push_back('{op: 4'd2, a: 6'd3, b: 6'd4});
      wait_idle(0, 50);
      check_eq("t4_count", 32'(rsp_log[0].size()), 32'd2);
      if (rsp_log[0].size() == 2) begin
         check_eq("t4_illegal_err", 32'(rsp_log[0][0].err), 32'd1);
         check_eq("t4_illegal_data", 32'(rsp_log[0][0].data), 32'd0);
         check_eq("t4_mul_err", 32'(rsp_log[0][1].err), 32'd0);
         check_eq("t4_mul_data", 32'(rsp_log[0][1].data), 32'd12);
      end

      // LAT=3 with response back-pressure: everything holds while stalled.
      rsp_mode[1] = 2;
      pend_q[1][0].push_back('{op: 4'd1, a: 6'd20, b: 6'd7});
      step(1);
      pend_q[1][1].push_back('{op: 4'd10, a: 6'd33, b: 6'd0});
      k = 0;
      while (rsp_valid[1] == 2'b00 && k < 20) begin
         step(1);
         k++;
      end
      check_eq("t5_rsp_seen", 32'(k < 20), 32'd1);
      for (int i = 0; i < 5; i++) begin
         check_eq("t5_hold_valid", 32'(rsp_valid[1]), 32'd1);
         check_eq("t5_hold_data", 32'(rsp_data[1]), 32'd13);
         check_eq("t5_hold_alu_a", 32'(alu_a[1]), 32'd20);
         check_eq("t5_hold_alu_b", 32'(alu_b[1]), 32'd7);
         check_eq("t5_hold_ready", 32'(req_ready[1]), 32'd0);
         step(1);
      end
      rsp_mode[1] = 1;
      wait_idle(1, 60);

      // Reset during WAIT discards the op; requester 0 wins afterwards.
      rsp_log[1].delete();
      pend_q[1][0].push_back('{op: 4'd0, a: 6'd1, b: 6'd1});
      k = 0;
      while (!m_busy[1] && k < 20) begin
         step(1);
         k++;
      end
      check_eq("t6_accepted", 32'(m_busy[1]), 32'd1);
      rst_n = 1'b0;
      pend_q[1][0].push_back('{op: 4'd0, a: 6'd2, b: 6'd3});
      pend_q[1][1].push_back('{op: 4'd0, a: 6'd4, b: 6'd5});
      step(2);
      rst_n = 1'b1;
      wait_idle(1, 60);
      check_eq("t6_count", 32'(rsp_log[1].size()), 32'd2);
      if (rsp_log[1].size() == 2) begin
         check_eq("t6_first_owner", 32'(rsp_log[1][0].owner), 32'd0);
         check_eq("t6_first_data", 32'(rsp_log[1][0].data), 32'd5);
         check_eq("t6_second_owner", 32'(rsp_log[1][1].owner), 32'd1);
         check_eq("t6_second_data", 32'(rsp_log[1][1].data), 32'd9);
      end

      // Randomized traffic on both instances with random response back-pressure.
      base0 = n_rsp[0];
      base1 = n_rsp[1];
      rand_en  = '{1'b1, 1'b1};
      rsp_mode = '{0, 0};
      step(800);
      rand_en  = '{1'b0, 1'b0};
      rsp_mode = '{1, 1};
      wait_idle(0, 100);
      wait_idle(1, 100);
      check_eq("rand_progress_l1", 32'(n_rsp[0] - base0 > 50), 32'd1);
      check_eq("rand_progress_l3", 32'(n_rsp[1] - base1 > 30), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
